// File: rtl/normalizer_pipe_if.sv
// normalizer_pipe_if: upstream word/handshake and downstream result/handshake bundle for normalizer_pipe
interface normalizer_pipe_if #(
   parameter int N     = 16,
   parameter int TAG_W = 4
);
   localparam int CW = $clog2(N + 1);
   logic             i_valid;
   logic             o_ready;
   logic [N:0]       i_in;
   logic             i_ozb;
   logic [TAG_W-1:0] i_tag;
   logic             o_valid;
   logic             i_ready;
   logic [N:0]       o_r;
   logic [CW-1:0]    o_count;
   logic             o_all;
   logic [TAG_W-1:0] o_tag;
   modport slave (
      input  i_valid, i_in, i_ozb, i_tag, i_ready,
      output o_ready, o_valid, o_r, o_count, o_all, o_tag
   );
   modport master (
      output i_valid, i_in, i_ozb, i_tag, i_ready,
      input  o_ready, o_valid, o_r, o_count, o_all, o_tag
   );
endinterface

// File: rtl/normalizer_pipe.sv
// normalizer_pipe: counts the leading i_ozb run of a word and shifts it out through a
// log shifter whose levels can each be followed by an elastic register stage.
module normalizer_pipe #(
   parameter int                       N        = 16,
   parameter int                       TAG_W    = 4,
   parameter logic [$clog2(N+1)-1:0]   REG_MASK = '1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   normalizer_pipe_if.slave bus
);
   localparam int L = $clog2(N + 1);
   logic out_v;
   logic unused_ozb;
   for (genvar k = 0; k < L; k++) begin : g
      localparam int S = 1 << (L - 1 - k);
      logic [N:0]       w_i, w_s, w_o;
      logic [L-1:0]     c_i, c_s, c_o;
      logic [TAG_W-1:0] t_i, t_o;
      logic             z_i, z_o, a_i, a_o, v_i, v_o, rdy_i, rdy_o, hit;
      if (k == 0) begin : src
         assign w_i = bus.i_in;
         assign c_i = '0;
         assign z_i = bus.i_ozb;
         assign a_i = (bus.i_in == {(N + 1){bus.i_ozb}});
         assign v_i = bus.i_valid;
         assign t_i = bus.i_tag;
      end else begin : src
         assign w_i = g[k-1].w_o;
         assign c_i = g[k-1].c_o;
         assign z_i = g[k-1].z_o;
         assign a_i = g[k-1].a_o;
         assign v_i = g[k-1].v_o;
         assign t_i = g[k-1].t_o;
      end
      if (k == L - 1) begin : snk
         assign rdy_o = bus.i_ready;
      end else begin : snk
         assign rdy_o = g[k+1].rdy_i;
      end
      // the count cap stops the shifter at N even when the whole word matches
      always_comb begin
         hit = (w_i[N -: S] == {S{z_i}}) && ((L + 1)'(c_i) + (L + 1)'(S) <= (L + 1)'(N));
         w_s = hit ? w_i << S : w_i;
         c_s = hit ? c_i + L'(S) : c_i;
      end
      if (REG_MASK[k]) begin : stage
         logic             ld, v_d, v_q, z_d, z_q, a_d, a_q;
         logic [N:0]       w_d, w_q;
         logic [L-1:0]     c_d, c_q;
         logic [TAG_W-1:0] t_d, t_q;
         always_comb begin
            ld  = !v_q || rdy_o;
            v_d = ld ? v_i : v_q;
            w_d = ld ? w_s : w_q;
            c_d = ld ? c_s : c_q;
            z_d = ld ? z_i : z_q;
            a_d = ld ? a_i : a_q;
            t_d = ld ? t_i : t_q;
         end
         always_ff @(posedge i_clk) begin
            v_q <= i_rst ? 1'b0 : v_d;
            w_q <= w_d;
            c_q <= c_d;
            z_q <= z_d;
            a_q <= a_d;
            t_q <= t_d;
         end
         assign rdy_i = ld;
         assign v_o   = v_q;
         assign w_o   = w_q;
         assign c_o   = c_q;
         assign z_o   = z_q;
         assign a_o   = a_q;
         assign t_o   = t_q;
      end else begin : thru
         assign rdy_i = rdy_o;
         assign v_o   = v_i;
         assign w_o   = w_s;
         assign c_o   = c_s;
         assign z_o   = z_i;
         assign a_o   = a_i;
         assign t_o   = t_i;
      end
   end
   assign unused_ozb  = g[L-1].z_o;
   assign out_v       = g[L-1].v_o && !i_rst;
   assign bus.o_valid = out_v;
   assign bus.o_ready = g[0].rdy_i && !i_rst;
   assign bus.o_r     = out_v ? g[L-1].w_o : '0;
   assign bus.o_count = out_v ? g[L-1].c_o : '0;
   assign bus.o_all   = out_v && g[L-1].a_o;
   assign bus.o_tag   = out_v ? g[L-1].t_o : '0;
endmodule

// File: tb/tb_normalizer_pipe.sv
// tb_normalizer_pipe: directed checks of a 3-stage N=16 pipe and a combinational N=32 instance
module tb_normalizer_pipe;
   logic clk = 0;
   logic rst = 1;
   always #5 clk = ~clk;
   int n_chk = 0;
   int n_bad = 0;
   int cyc = 0;
   int waits = 0;
   bit saw_full = 0;
   bit lat_on = 1;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {logic [16:0] r; logic [4:0] c; logic a; logic [3:0] t;} res_t;
   typedef struct {res_t e; int acc; bit lat;} exp_t;
   exp_t sb[$];
   logic [16:0] bp_in [6] = '{17'h00001, 17'h1FFFF, 17'h0FF00, 17'h1C000, 17'h10000, 17'h00000};
   logic        bp_z  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   normalizer_pipe_if #(.N(16), .TAG_W(4)) b0 ();
   normalizer_pipe_if #(.N(32), .TAG_W(4)) b1 ();
   normalizer_pipe #(.N(16), .TAG_W(4), .REG_MASK(5'b10101)) u0 (.i_clk(clk), .i_rst(rst), .bus(b0.slave));
   normalizer_pipe #(.N(32), .TAG_W(4), .REG_MASK(6'b000000)) u1 (.i_clk(clk), .i_rst(rst), .bus(b1.slave));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic res_t model(input logic [16:0] in, input logic z, input logic [3:0] t);
      res_t m;
      int run;
      run = 0;
      for (int i = 16; i >= 0; i--) begin
         if (in[i] != z) break;
         run++;
      end
      m.c = 5'(run > 16 ? 16 : run);
      m.r = in << m.c;
      m.a = (run == 17);
      m.t = t;
      return m;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle();
      b0.i_valid = 0;
      b0.i_in = '0;
   endtask

   task automatic send(input logic [16:0] in, input logic z, input logic [3:0] t, input res_t e, input bit push);
      int n;
      n = 0;
      b0.i_valid = 1;
      b0.i_in = in;
      b0.i_ozb = z;
      b0.i_tag = t;
      forever begin
         @(negedge clk);
         if (b0.o_ready) break;
         saw_full = 1;
         waits++;
         n++;
         if (n > 50) begin
            chk("send_timeout", 64'(b0.o_ready), 64'd1);
            idle();
            return;
         end
         @(posedge clk);
         #1;
      end
      if (push) sb.push_back('{e, cyc, lat_on});
      @(posedge clk);
      #1;
   endtask

   initial begin
      res_t snap;
      exp_t x;
      bit held;
      held = 0;
      forever begin
         @(negedge clk);
         if (!b0.o_valid) held = 0;
         else begin
            if (held) begin
               chk("hold_r", 64'(b0.o_r), 64'(snap.r));
               chk("hold_count", 64'(b0.o_count), 64'(snap.c));
               chk("hold_all", 64'(b0.o_all), 64'(snap.a));
               chk("hold_tag", 64'(b0.o_tag), 64'(snap.t));
            end
            if (!b0.i_ready) begin
               held = 1;
               snap = {b0.o_r, b0.o_count, b0.o_all, b0.o_tag};
            end else begin
               held = 0;
               if (sb.size() == 0) chk("unexpected_out", 64'(b0.o_valid), 64'd0);
               else begin
                  x = sb.pop_front();
                  chk("out_r", 64'(b0.o_r), 64'(x.e.r));
                  chk("out_count", 64'(b0.o_count), 64'(x.e.c));
                  chk("out_all", 64'(b0.o_all), 64'(x.e.a));
                  chk("out_tag", 64'(b0.o_tag), 64'(x.e.t));
                  if (x.lat) chk("latency", 64'(cyc - x.acc), 64'd3);
               end
            end
         end
      end
   end

   initial begin
      int n;
      b0.i_valid = 1; b0.i_in = 17'h00001; b0.i_ozb = 0; b0.i_tag = 4'hF; b0.i_ready = 1;
      b1.i_valid = 1; b1.i_in = 33'h1; b1.i_ozb = 0; b1.i_tag = 4'hF; b1.i_ready = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 64'(b0.o_valid), 64'd0);
      chk("rst_ready", 64'(b0.o_ready), 64'd0);
      chk("rst_r", 64'(b0.o_r), 64'd0);
      chk("rst_count", 64'(b0.o_count), 64'd0);
      chk("rst_all", 64'(b0.o_all), 64'd0);
      chk("rst_tag", 64'(b0.o_tag), 64'd0);
      chk("rst_comb_valid", 64'(b1.o_valid), 64'd0);
      chk("rst_comb_ready", 64'(b1.o_ready), 64'd0);
      @(posedge clk);
      #1;
      rst = 0;
      idle();
      b1.i_valid = 0;
      @(negedge clk);
      chk("ready_after_rst", 64'(b0.o_ready), 64'd1);
      tick(1);
      send(17'h000F0, 1'b0, 4'hA, {17'h1E000, 5'd9, 1'b0, 4'hA}, 1);
      idle();
      tick(5);
      send(17'h1FFFE, 1'b1, 4'h1, {17'h00000, 5'd16, 1'b0, 4'h1}, 1);
      send(17'h00000, 1'b0, 4'h2, {17'h00000, 5'd16, 1'b1, 4'h2}, 1);
      idle();
      tick(5);
      lat_on = 0;
      saw_full = 0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(bp_in[i], bp_z[i], 4'(i), model(bp_in[i], bp_z[i], 4'(i)), 1);
            idle();
         end
         begin
            tick(3);
            b0.i_ready = 0;
            tick(6);
            b0.i_ready = 1;
         end
      join
      chk("bp_ready_fell", 64'(saw_full), 64'd1);
      tick(10);
      chk("bp_drained", 64'(sb.size()), 64'd0);
      lat_on = 1;
      waits = 0;
      for (int i = 0; i < 100; i++) begin
         logic [16:0] in;
         logic z;
         in = 17'($urandom) >> $urandom_range(0, 17);
         z = 1'($urandom_range(0, 1));
         if (z) in = ~in;
         send(in, z, 4'(i), model(in, z, 4'(i)), 1);
      end
      idle();
      tick(8);
      chk("stream_waits", 64'(waits), 64'd0);
      send(17'h00F00, 1'b0, 4'h3, '0, 0);
      send(17'h1F000, 1'b1, 4'h4, '0, 0);
      idle();
      rst = 1;
      @(negedge clk);
      chk("midrst_valid", 64'(b0.o_valid), 64'd0);
      chk("midrst_ready", 64'(b0.o_ready), 64'd0);
      @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      chk("midrst_ready_rise", 64'(b0.o_ready), 64'd1);
      repeat (5) begin
         @(negedge clk);
         chk("no_stale", 64'(b0.o_valid), 64'd0);
      end
      tick(1);
      send(17'h00003, 1'b0, 4'h7, {17'h18000, 5'd15, 1'b0, 4'h7}, 1);
      idle();
      tick(6);
      b1.i_ready = 1; b1.i_valid = 1; b1.i_in = 33'h000000001; b1.i_ozb = 0; b1.i_tag = 4'h5;
      #1;
      chk("comb_valid", 64'(b1.o_valid), 64'd1);
      chk("comb_count", 64'(b1.o_count), 64'd32);
      chk("comb_r", 64'(b1.o_r), 64'h100000000);
      chk("comb_all", 64'(b1.o_all), 64'd0);
      chk("comb_tag", 64'(b1.o_tag), 64'd5);
      chk("comb_ready_hi", 64'(b1.o_ready), 64'd1);
      b1.i_ready = 0;
      #1;
      chk("comb_ready_lo", 64'(b1.o_ready), 64'd0);
      b1.i_ready = 1; b1.i_in = 33'h1FFFFFFFF; b1.i_ozb = 1;
      #1;
      chk("comb_ones_count", 64'(b1.o_count), 64'd32);
      chk("comb_ones_r", 64'(b1.o_r), 64'h100000000);
      chk("comb_ones_all", 64'(b1.o_all), 64'd1);
      b1.i_valid = 0;
      #1;
      chk("comb_idle_valid", 64'(b1.o_valid), 64'd0);
      chk("comb_idle_r", 64'(b1.o_r), 64'd0);
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("final_drain", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/normalizer_pipe.md
Name: normalizer_pipe

Overview:
- Parametrised, pipelined successor of the 16-bit posit leading-run normalizer.
- Counts the leading run of bits equal to `i_ozb` in an (N+1)-bit word, then left-shifts that run out with zero fill.
- Adds a valid/ready handshake, selectable pipeline registers between shift levels, an all-equal flag and a passthrough tag.
- Sits between the posit adder/multiplier significand datapath and the rounding/encode stage.

Parameters:
- N, 16, data width is N+1 bits (`i_in`, `o_r`); N >= 2.
- TAG_W, 4, width of the opaque sideband tag carried alongside each word; >= 1.
- L, $clog2(N+1), number of shift levels (derived; not overridden).
- REG_MASK, {L{1'b1}}, L-bit mask; bit k = 1 places a register after shift level k (level 0 shifts by 2^(L-1)).

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  upstream word valid.
- o_ready  out  1  block can accept a word this cycle.
- i_in  in  N+1  word to normalise.
- i_ozb  in  1  run polarity: count leading bits equal to this value.
- i_tag  in  TAG_W  sideband, returned unchanged with its result.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_r  out  N+1  normalised word.
- o_count  out  $clog2(N+1)  shift amount applied.
- o_all  out  1  all N+1 input bits equal `i_ozb`.
- o_tag  out  TAG_W  tag of the word on `o_r`.

Behaviour:
- Single clock `i_clk`; reset `i_rst` is synchronous and active-high.
- Arithmetic:
  - r = length of the leading run of `i_in` bits equal to `i_ozb`.
  - o_count = min(r, N).
  - o_r = i_in << o_count, zero filled.
  - o_all = (r == N+1).
- Shift levels: level k uses shift s = 2^(L-1-k).
  - Shift if the top s bits of the current word all equal `i_ozb` AND accumulated count + s <= N.
  - Otherwise pass through unchanged.
  - Count accumulates MSB-first.
  - o_all is computed from the original `i_in` and carried down the pipe.
- Examples at N=16:
  - all-ones input with ozb=1 -> count 16, o_r = 17'h10000.
  - all-zero input with ozb=0 -> count 16, o_r = 0, o_all = 1.
- Latency = popcount(REG_MASK) cycles from accept to o_valid.
  - REG_MASK = 0 is fully combinational: o_valid = i_valid, o_ready = i_ready.
- Every register stage holds {valid, word, count, ozb, all, tag}.
- Handshake:
  - Transfer in when i_valid & o_ready; transfer out when o_valid & i_ready.
  - Stage p may load when it is empty OR the stage after it (or the output, for the last stage) is transferring this cycle.
  - o_ready = load-enable of the first register stage. This is a combinational path from i_ready only when all stages are full.
  - While o_valid & !i_ready: o_r, o_count, o_all and o_tag are held stable, and no stage overwrites a full, stalled stage.
- Throughput: one word per cycle when i_ready is held high; no bubbles inserted.
- Ordering: strictly in order; no drops; no duplicates.
- Empty-stage payload registers are don't-care internally, but outputs are driven 0 when o_valid = 0.
- Reset:
  - While i_rst is high: all stage valids clear, o_valid = 0, o_r = 0, o_count = 0, o_all = 0, o_tag = 0, o_ready = 0.
  - o_ready rises in the first cycle after i_rst falls.
  - Reset mid-flight discards all in-flight words; no output appears for them.
- Simultaneous in/out transfer on a full pipe is legal and keeps occupancy constant.
- i_ozb is sampled per word together with i_in; changing it between words is legal.

Test Plan:
1. N=16, REG_MASK=5'b10101, i_in=17'h000F0, ozb=0, i_ready=1 -> after 3 cycles: o_count=9, o_r=17'h1E000, o_all=0, o_tag echoed.
2. i_in=17'h1FFFE, ozb=1 -> o_count=16, o_r=17'h00000, o_all=0. Then i_in=17'h00000, ozb=0 -> o_count=16, o_r=0, o_all=1.
3. Backpressure: 6 back-to-back words, tags 0..5, i_ready low cycles 4-9 -> o_ready falls once 3 stages are full; outputs stable while stalled; all 6 results arrive in tag order with correct values.
4. Streaming: 100 random words with i_ready=1 -> one result per cycle after a 3-cycle fill. Each result equals the reference model: min(run, 16), shifted word, all flag.
5. Reset mid-flight: 2 words accepted, i_rst pulsed 1 cycle before they exit -> o_valid stays 0, no stale result appears; a new word afterwards is correct with latency 3.
6. REG_MASK=0, N=32 -> same-cycle results; o_ready tracks i_ready. i_in=33'h000000001, ozb=0 -> o_count=32, o_r=33'h100000000.
